// File: rtl/ps2_num_entry_if.sv
// Operand/handshake bundle between the PS/2 number-entry block and the calculator core.
// The producer (ps2_num_entry) uses the master modport; the consumer uses slave.
interface ps2_num_entry_if #(
  parameter int NDIGITS = 4,
  parameter int VAL_W   = 14
);
  logic [4*NDIGITS-1:0]         digits_bcd;
  logic [$clog2(NDIGITS+1)-1:0] ndig;
  logic [VAL_W-1:0]             val_out;
  logic [2:0]                   op_out;
  logic                         valid;
  logic                         ack;

  modport master (
    output digits_bcd, ndig, val_out, op_out, valid,
    input  ack
  );

  modport slave (
    input  digits_bcd, ndig, val_out, op_out, valid,
    output ack
  );
endinterface

// File: rtl/ps2_num_entry.sv
// PS/2 set-2 keypad number entry: frame receiver, prefix decoder, digit entry and BCD-to-binary.
// Optional macro PS2_PARITY_CHK_EN enables odd-parity checking of received frames.
module ps2_num_entry #(
  parameter int NDIGITS     = 4,
  parameter int VAL_W       = 14,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic frame_err_o,
  ps2_num_entry_if.master ent
);

  localparam int NW = $clog2(NDIGITS + 1);
  localparam int DW = 4 * NDIGITS;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
`ifdef PS2_PARITY_CHK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {RX_IDLE, RX_SHIFT, RX_CHECK} rx_state_e;
  typedef enum logic [1:0] {EN_ENTRY, EN_CONVERT, EN_HOLD} en_state_e;

  // Odd parity over data+parity is the good case.
  function automatic logic parity_odd(input logic [8:0] bits);
    return ^bits;
  endfunction

  // Returns {is_digit, value} for a make code.
  function automatic logic [4:0] digit_lookup(input logic [7:0] code);
    logic [4:0] res;
    case (code)
      8'h70:   res = 5'b1_0000;
      8'h69:   res = 5'b1_0001;
      8'h72:   res = 5'b1_0010;
      8'h7A:   res = 5'b1_0011;
      8'h6B:   res = 5'b1_0100;
      8'h73:   res = 5'b1_0101;
      8'h74:   res = 5'b1_0110;
      8'h6C:   res = 5'b1_0111;
      8'h75:   res = 5'b1_1000;
      8'h7D:   res = 5'b1_1001;
      default: res = 5'b0_0000;
    endcase
    return res;
  endfunction

  logic ps2c_meta_q, ps2c_sync_q, ps2c_prev_q;
  logic ps2d_meta_q, ps2d_sync_q;
  logic fall_s;

  rx_state_e       rx_state_q, rx_state_d;
  logic [9:0]      shreg_q, shreg_d;
  logic [3:0]      bitcnt_q, bitcnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            code_stb_s, rx_err_s, frame_ok_s;
  logic            frame_err_q;

  logic            break_q, break_d, ext_q, ext_d;
  logic            key_en_s, key_dig_s, key_term_s, key_bs_s, key_clr_s;
  logic [3:0]      key_val_s;
  logic [2:0]      key_op_s;
  logic [4:0]      dig_lu_s;
  logic [7:0]      code_s;

  en_state_e       en_state_q, en_state_d;
  logic [DW-1:0]   digits_q, digits_d;
  logic [NW-1:0]   ndig_q, ndig_d;
  logic [NW-1:0]   cnt_q, cnt_d;
  logic [VAL_W-1:0] acc_q, acc_d, val_q, val_d, acc_next_s;
  logic [2:0]      op_pend_q, op_pend_d, op_q, op_d;
  logic            valid_q, valid_d;
  logic [3:0]      digit_s;

  // Two-flop synchronisers plus previous-value flop for falling-edge detection.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ps2c_meta_q <= 1'b1;
      ps2c_sync_q <= 1'b1;
      ps2c_prev_q <= 1'b1;
      ps2d_meta_q <= 1'b1;
      ps2d_sync_q <= 1'b1;
    end else begin
      ps2c_meta_q <= ps2_clk_i;
      ps2c_sync_q <= ps2c_meta_q;
      ps2c_prev_q <= ps2c_sync_q;
      ps2d_meta_q <= ps2_data_i;
      ps2d_sync_q <= ps2d_meta_q;
    end
  end

  assign fall_s     = ps2c_prev_q & ~ps2c_sync_q;
  assign code_s     = shreg_q[7:0];
  assign frame_ok_s = shreg_q[9] & (PAR_EN ? parity_odd(shreg_q[8:0]) : 1'b1);

  // Receiver state register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rx_state_q  <= RX_IDLE;
      shreg_q     <= 10'd0;
      bitcnt_q    <= 4'd0;
      tmo_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      shreg_q     <= shreg_d;
      bitcnt_q    <= bitcnt_d;
      tmo_q       <= tmo_d;
      frame_err_q <= rx_err_s;
    end
  end

  // Receiver next state: 10 bits after the start bit (8 data, parity, stop), LSB first.
  always_comb begin
    rx_state_d = rx_state_q;
    shreg_d    = shreg_q;
    bitcnt_d   = bitcnt_q;
    tmo_d      = tmo_q;
    code_stb_s = 1'b0;
    rx_err_s   = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        tmo_d = '0;
        if (fall_s && !ps2d_sync_q) begin
          rx_state_d = RX_SHIFT;
          bitcnt_d   = 4'd0;
        end else begin
          rx_state_d = RX_IDLE;
        end
      end
      RX_SHIFT: begin
        if (fall_s) begin
          shreg_d  = {ps2d_sync_q, shreg_q[9:1]};
          bitcnt_d = bitcnt_q + 4'd1;
          tmo_d    = '0;
          if (bitcnt_q == 4'd9) begin
            rx_state_d = RX_CHECK;
          end else begin
            rx_state_d = RX_SHIFT;
          end
        end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          rx_state_d = RX_IDLE;
          rx_err_s   = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1'b1);
        end
      end
      RX_CHECK: begin
        rx_state_d = RX_IDLE;
        if (frame_ok_s) begin
          code_stb_s = 1'b1;
        end else begin
          rx_err_s = 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Key decode: prefixes only update flags; a code following F0 is a release and is dropped.
  always_comb begin
    break_d    = break_q;
    ext_d      = ext_q;
    key_en_s   = 1'b0;
    key_dig_s  = 1'b0;
    key_val_s  = 4'd0;
    key_term_s = 1'b0;
    key_op_s   = 3'd0;
    key_bs_s   = 1'b0;
    key_clr_s  = 1'b0;
    dig_lu_s   = digit_lookup(code_s);
    if (code_stb_s) begin
      if (code_s == 8'hF0) begin
        break_d = 1'b1;
      end else if (code_s == 8'hE0) begin
        ext_d = 1'b1;
      end else begin
        key_en_s = ~break_q;
        break_d  = 1'b0;
        ext_d    = 1'b0;
      end
    end else begin
      key_en_s = 1'b0;
    end
    if (key_en_s && !ext_q) begin
      case (code_s)
        8'h79: begin key_term_s = 1'b1; key_op_s = 3'd1; end
        8'h7B: begin key_term_s = 1'b1; key_op_s = 3'd2; end
        8'h7C: begin key_term_s = 1'b1; key_op_s = 3'd3; end
        8'h5A: begin key_term_s = 1'b1; key_op_s = 3'd0; end
        8'h66: key_bs_s = 1'b1;
        8'h76: key_clr_s = 1'b1;
        default: begin
          key_dig_s = dig_lu_s[4];
          key_val_s = dig_lu_s[3:0];
        end
      endcase
    end else if (key_en_s && ext_q) begin
      case (code_s)
        8'h4A: begin key_term_s = 1'b1; key_op_s = 3'd4; end
        8'h5A: begin key_term_s = 1'b1; key_op_s = 3'd0; end
        default: key_term_s = 1'b0;
      endcase
    end else begin
      key_term_s = 1'b0;
    end
  end

  // Digit selected for the current conversion step (cnt_q counts MSD down to LSD).
  always_comb begin
    digit_s = 4'd0;
    for (int i = 0; i < NDIGITS; i++) begin
      digit_s = digit_s | ((cnt_q == NW'(i)) ? digits_q[4*i +: 4] : 4'd0);
    end
  end

  assign acc_next_s = acc_q * VAL_W'(4'd10) + VAL_W'(digit_s);

  // Entry FSM state and datapath registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      en_state_q <= EN_ENTRY;
      digits_q   <= '0;
      ndig_q     <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      val_q      <= '0;
      op_pend_q  <= 3'd0;
      op_q       <= 3'd0;
      valid_q    <= 1'b0;
      break_q    <= 1'b0;
      ext_q      <= 1'b0;
    end else begin
      en_state_q <= en_state_d;
      digits_q   <= digits_d;
      ndig_q     <= ndig_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      val_q      <= val_d;
      op_pend_q  <= op_pend_d;
      op_q       <= op_d;
      valid_q    <= valid_d;
      break_q    <= break_d;
      ext_q      <= ext_d;
    end
  end

  // Entry FSM: edit in ENTRY, NDIGITS-cycle conversion, then hold until acknowledged.
  always_comb begin
    en_state_d = en_state_q;
    digits_d   = digits_q;
    ndig_d     = ndig_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    val_d      = val_q;
    op_pend_d  = op_pend_q;
    op_d       = op_q;
    valid_d    = valid_q;
    case (en_state_q)
      EN_ENTRY: begin
        if (key_dig_s && (ndig_q < NW'(NDIGITS))) begin
          digits_d = DW'({digits_q, key_val_s});
          ndig_d   = ndig_q + NW'(1'b1);
        end else if (key_bs_s && (ndig_q != '0)) begin
          digits_d = digits_q >> 4'd4;
          ndig_d   = ndig_q - NW'(1'b1);
        end else if (key_clr_s) begin
          digits_d = '0;
          ndig_d   = '0;
        end else if (key_term_s) begin
          op_pend_d  = key_op_s;
          acc_d      = '0;
          cnt_d      = NW'(NDIGITS - 1);
          en_state_d = EN_CONVERT;
        end else begin
          en_state_d = EN_ENTRY;
        end
      end
      EN_CONVERT: begin
        acc_d = acc_next_s;
        if (cnt_q == '0) begin
          val_d      = acc_next_s;
          op_d       = op_pend_q;
          valid_d    = 1'b1;
          en_state_d = EN_HOLD;
        end else begin
          cnt_d = cnt_q - NW'(1'b1);
        end
      end
      EN_HOLD: begin
        if (valid_q && ent.ack) begin
          valid_d    = 1'b0;
          digits_d   = '0;
          ndig_d     = '0;
          en_state_d = EN_ENTRY;
        end else begin
          en_state_d = EN_HOLD;
        end
      end
      default: en_state_d = EN_ENTRY;
    endcase
  end

  assign ent.digits_bcd = digits_q;
  assign ent.ndig       = ndig_q;
  assign ent.val_out    = val_q;
  assign ent.op_out     = op_q;
  assign ent.valid      = valid_q;
  assign frame_err_o    = frame_err_q;

endmodule

// File: tb/tb_ps2_num_entry.sv
// Directed bench for ps2_num_entry: bit-banged PS/2 frames, hand-computed expectations.
module tb_ps2_num_entry;
  localparam int NDIGITS = 4;
  localparam int VAL_W   = 14;
  localparam int TMO     = 300;
  localparam int HP      = 8;

  logic clk = 1'b0;
  logic rst_n, ps2_clk, ps2_data, frame_err;
  int   checks = 0;
  int   errors = 0;
  int   ferr_cnt = 0;
  logic [7:0] dig_code [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};

  ps2_num_entry_if #(.NDIGITS(NDIGITS), .VAL_W(VAL_W)) ent_if ();

  ps2_num_entry #(.NDIGITS(NDIGITS), .VAL_W(VAL_W), .TIMEOUT_CYC(TMO)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .ps2_clk_i  (ps2_clk),
    .ps2_data_i (ps2_data),
    .frame_err_o(frame_err),
    .ent        (ent_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(ent_if.valid), 32'd0);
    check({tag, "_ndig"}, 32'(ent_if.ndig), 32'd0);
    check({tag, "_digits"}, 32'(ent_if.digits_bcd), 32'd0);
    check({tag, "_val"}, 32'(ent_if.val_out), 32'd0);
    check({tag, "_op"}, 32'(ent_if.op_out), 32'd0);
    check({tag, "_ferr"}, 32'(frame_err), 32'd0);
  endtask

  // mode 0: plain frame; 1: check valid latency after stop bit; 2: reset during conversion
  task automatic send_frame(input logic [7:0] code, input logic bad_par, input int mode);
    logic [10:0] bits;
    bits = {1'b1, (~^code) ^ bad_par, code, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2_data = bits[i];
      repeat (HP / 2) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10 && mode == 1) begin
        repeat (7) @(posedge clk);
        #1 check("valid_before_T+N+1", 32'(ent_if.valid), 32'd0);
        @(posedge clk);
        #1 check("valid_at_T+N+1", 32'(ent_if.valid), 32'd1);
        @(negedge clk);
      end else if (i == 10 && mode == 2) begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 check_all_zero("rst_in_convert");
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        repeat (HP) @(negedge clk);
      end
      ps2_clk = 1'b1;
      repeat (HP / 2) @(negedge clk);
    end
    repeat (HP) @(negedge clk);
  endtask

  task automatic press(input logic [7:0] code);
    send_frame(code, 1'b0, 0);
    send_frame(8'hF0, 1'b0, 0);
    send_frame(code, 1'b0, 0);
  endtask

  task automatic do_ack();
    @(negedge clk);
    ent_if.ack = 1'b1;
    @(negedge clk);
    ent_if.ack = 1'b0;
    check("ack_valid_drop", 32'(ent_if.valid), 32'd0);
    check("ack_ndig_clear", 32'(ent_if.ndig), 32'd0);
    check("ack_digits_clear", 32'(ent_if.digits_bcd), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    ent_if.ack = 1'b0;
    repeat (4) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 1 2 3 Enter -> 123, valid exactly NDIGITS+1 cycles after acceptance
    press(8'h69);
    check("ndig_1", 32'(ent_if.ndig), 32'd1);
    press(8'h72);
    check("ndig_2", 32'(ent_if.ndig), 32'd2);
    press(8'h7A);
    check("ndig_3", 32'(ent_if.ndig), 32'd3);
    check("digits_123", 32'(ent_if.digits_bcd), 32'h0123);
    send_frame(8'h5A, 1'b0, 1);
    send_frame(8'hF0, 1'b0, 0);
    send_frame(8'h5A, 1'b0, 0);
    check("val_123", 32'(ent_if.val_out), 32'd123);
    check("op_enter", 32'(ent_if.op_out), 32'd0);
    check("valid_hold", 32'(ent_if.valid), 32'd1);
    do_ack();

    // 1 2 3 4 5 + -> fifth digit ignored
    for (int d = 1; d <= 5; d++) press(dig_code[d]);
    check("ndig_full", 32'(ent_if.ndig), 32'd4);
    check("digits_1234", 32'(ent_if.digits_bcd), 32'h1234);
    press(8'h79);
    check("val_1234", 32'(ent_if.val_out), 32'd1234);
    check("op_plus", 32'(ent_if.op_out), 32'd1);
    check("valid_plus", 32'(ent_if.valid), 32'd1);
    do_ack();

    // 7 5 BS 2 E0-Enter -> 72
    press(8'h6C);
    press(8'h73);
    press(8'h66);
    check("bs_ndig", 32'(ent_if.ndig), 32'd1);
    check("bs_digits", 32'(ent_if.digits_bcd), 32'h0007);
    press(8'h72);
    check("digits_72", 32'(ent_if.digits_bcd), 32'h0072);
    send_frame(8'hE0, 1'b0, 0);
    send_frame(8'h5A, 1'b0, 0);
    send_frame(8'hE0, 1'b0, 0);
    press(8'h5A);
    check("val_72", 32'(ent_if.val_out), 32'd72);
    check("op_ext_enter", 32'(ent_if.op_out), 32'd0);
    check("valid_72", 32'(ent_if.valid), 32'd1);
    do_ack();
    check("no_ferr_yet", 32'(ferr_cnt), 32'd0);

    // wrong parity on 0x69
    send_frame(8'h69, 1'b1, 0);
`ifdef PS2_PARITY_CHK_EN
    check("par_ferr", 32'(ferr_cnt), 32'd1);
    check("par_ndig", 32'(ent_if.ndig), 32'd0);
`else
    check("par_ferr", 32'(ferr_cnt), 32'd0);
    check("par_ndig", 32'(ent_if.ndig), 32'd1);
    check("par_digits", 32'(ent_if.digits_bcd), 32'h0001);
`endif
    send_frame(8'hF0, 1'b0, 0);
    send_frame(8'h69, 1'b0, 0);
    press(8'h76);
    check("clear_ndig", 32'(ent_if.ndig), 32'd0);
    check("clear_digits", 32'(ent_if.digits_bcd), 32'd0);

    // 5 bits then silence -> timeout
    begin
      logic [7:0] c;
      logic [10:0] bits;
      int base;
      c = 8'h69;
      bits = {1'b1, ~^c, c, 1'b0};
      base = ferr_cnt;
      for (int i = 0; i < 5; i++) begin
        ps2_data = bits[i];
        repeat (HP / 2) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HP) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HP / 2) @(negedge clk);
      end
      ps2_data = 1'b1;
      repeat (TMO + 30) @(negedge clk);
      check("tmo_ferr", 32'(ferr_cnt - base), 32'd1);
      check("tmo_ndig", 32'(ent_if.ndig), 32'd0);
    end
    press(8'h70);
    check("post_tmo_ndig", 32'(ent_if.ndig), 32'd1);
    check("post_tmo_digit0", 32'(ent_if.digits_bcd), 32'h0000);
    press(8'h76);

    // 8 / -> op 4
    press(8'h75);
    send_frame(8'hE0, 1'b0, 0);
    send_frame(8'h4A, 1'b0, 0);
    send_frame(8'hE0, 1'b0, 0);
    press(8'h4A);
    check("val_8", 32'(ent_if.val_out), 32'd8);
    check("op_div", 32'(ent_if.op_out), 32'd4);
    do_ack();

    // reset in CONVERT, then 9999
    press(8'h73);
    press(8'h74);
    send_frame(8'h5A, 1'b0, 2);
    repeat (20) @(negedge clk);
    check("post_rst_valid", 32'(ent_if.valid), 32'd0);
    check("post_rst_val", 32'(ent_if.val_out), 32'd0);
    for (int k = 0; k < 4; k++) press(dig_code[9]);
    check("digits_9999", 32'(ent_if.digits_bcd), 32'h9999);
    press(8'h5A);
    check("val_9999", 32'(ent_if.val_out), 32'd9999);
    check("valid_9999", 32'(ent_if.valid), 32'd1);
    do_ack();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_num_entry.md
# ps2_num_entry

Parametrised PS/2 keypad number-entry block, successor to the single-purpose keyboard decoder. It receives PS/2 set-2 frames and checks start, stop and (optionally) parity bits, with a receive timeout. It handles break (F0) and extended (E0) prefixes and collects up to NDIGITS decimal digits with backspace and clear. On Enter or an operator key it converts the BCD entry to binary sequentially and presents the operand and operator to the calculator core over a valid/ack handshake.

## Interface
- NDIGITS, 4: maximum decimal digits held (1..8).
- VAL_W, 14: binary result width; must be ≥ ceil(log2(10^NDIGITS)), otherwise the result wraps modulo 2^VAL_W.
- TIMEOUT_CYC, 50000: clk cycles allowed between PS/2 falling edges inside a frame.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- PS2_CLK  in  1  raw PS/2 clock (asynchronous).
- PS2_DATA  in  1  raw PS/2 data (asynchronous).
- digits_bcd  out  4*NDIGITS  live entry; digit 0 (least significant) is in [3:0].
- ndig  out  $clog2(NDIGITS+1)  number of digits entered.
- val_out  out  VAL_W  converted operand; stable while valid=1.
- op_out  out  3  terminator: 0 Enter, 1 +, 2 -, 3 *, 4 /.
- valid  out  1  operand available.
- ack  in  1  consumer accepts the operand.
- frame_err  out  1  one-cycle pulse on a bad or timed-out frame.

## Operation
- Synchronisers: 2-flop synchronisers on PS2_CLK and PS2_DATA. Data is sampled on the synchronised falling edge.
- Receiver FSM:
  - IDLE → SHIFT when the start bit (0) is sampled.
  - SHIFT collects 8 data bits (LSB first), then parity, then stop, and moves to CHECK.
  - CHECK: the frame is good if stop=1 and, when enabled, parity is odd. A good frame produces a one-cycle code strobe; a bad frame pulses frame_err. CHECK → IDLE.
  - SHIFT with TIMEOUT_CYC cycles and no falling edge → IDLE, frame_err pulse, partial byte discarded.
- Decoder:
  - F0 sets the break flag. The next code clears it and is ignored.
  - E0 sets the ext flag, which is cleared after the next non-prefix code.
- Make codes:
  - Digits: 70=0, 69=1, 72=2, 7A=3, 6B=4, 73=5, 74=6, 6C=7, 75=8, 7D=9.
  - Operators: 79 (+), 7B (-), 7C (*), E0 4A (/).
  - Enter: 5A or E0 5A.
  - Edit keys: 66 backspace, 76 clear.
  - All other codes are ignored.
- Entry FSM ENTRY:
  - Digit with ndig<NDIGITS: shifts into digit 0, existing digits move up, ndig+1.
  - Digit with ndig=NDIGITS: ignored.
  - Backspace: shifts digits down, zero fills the top digit, ndig−1; no-op if ndig=0.
  - Clear: digits and ndig are set to 0.
  - Operator or Enter: op_out is latched, acc is set to 0, FSM → CONVERT. Enter with ndig=0 is still accepted (val_out=0).
- CONVERT runs exactly NDIGITS cycles, most significant digit first: acc = acc*10 + digit, truncated to VAL_W bits. After the last cycle: val_out is loaded, valid=1, FSM → HOLD.
- HOLD: when valid&ack, valid drops, digits and ndig are cleared, FSM → ENTRY.
- Codes decoded while in CONVERT or HOLD are discarded. The break/ext flags are still tracked.

## Timing
- Reset values: every output is 0, both FSMs are in IDLE/ENTRY, and the prefix flags are cleared. Reset at any cycle, including mid-frame and mid-conversion, takes effect at the next clk edge. A conversion in progress never asserts valid.
- PS/2 inputs reach the sampling logic with 2 cycles of synchroniser latency.
- The code strobe occurs 1 cycle after the falling edge that samples the stop bit is seen. The digit/ndig update follows 1 cycle after the strobe.
- Terminator accepted at cycle T:
  - CONVERT occupies cycles T+1..T+NDIGITS.
  - valid=1 from T+NDIGITS+1.
- ack may be high before valid; transfer happens on the first cycle with both high, and valid=0 on the next cycle.
- val_out and op_out hold their values until the next conversion completes.
- A frame_err pulse and a code strobe never occur in the same cycle.

## Configuration
- PS2_PARITY_CHK_EN defined: a frame with even parity over data plus parity bit is rejected (frame_err pulse, no strobe).
- PS2_PARITY_CHK_EN not defined: the parity bit is shifted in and ignored; only start and stop are checked.

## Test plan
All scenarios use defaults NDIGITS=4, VAL_W=14 and PS2_PARITY_CHK_EN defined unless stated.
- Send 69,F0,69, 72,F0,72, 7A,F0,7A, 5A,F0,5A → ndig goes 1,2,3; then val_out=123, op_out=0, valid=1 exactly 5 cycles after Enter is accepted. Pulse ack → valid=0 next cycle, ndig=0.
- Send digits 1,2,3,4,5 then 79 → the fifth digit is ignored, digits_bcd=0x1234, val_out=1234, op_out=1.
- Send 6C, 73, 66, 72, E0 5A → digits_bcd=0x0072 before Enter; val_out=72, op_out=0.
- Send 0x69 with a wrong parity bit → frame_err pulse, ndig unchanged. Rebuild without the macro → digit 1 is accepted.
- Send 5 bits, stop PS2_CLK for 50000 cycles → frame_err pulse, receiver idle; the next clean 0x70 gives ndig=1, digit 0=0.
- Drive rst=0 during CONVERT → next cycle all outputs are 0 and valid stays 0; the next entry of 9,9,9,9, Enter gives val_out=9999.
